// File: rtl/reindeer_mm_timer_hub_pkg.sv
// Shared constants for the Reindeer timer hub: register map, bus widths,
// FSM encodings and small helpers used by the hub and its prescaler.
package reindeer_mm_timer_hub_pkg;

    localparam int XLEN       = 32;
    localparam int XLEN_BYTES = XLEN / 8;

    localparam int REG_MTIME_LO   = 0;
    localparam int REG_MTIME_HI   = 1;
    localparam int REG_PRESCALER  = 2;
    localparam int REG_IRQ_EN     = 3;
    localparam int REG_IRQ_STATUS = 4;
    localparam int CMP_BASE       = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Highest local word address for a hub with n compare channels.
    function automatic int local_top(input int n);
        return 7 + 2 * n;
    endfunction

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]       old_word,
                                                    input logic [XLEN-1:0]       new_word,
                                                    input logic [XLEN_BYTES-1:0] be);
        logic [XLEN-1:0] result;
        result = old_word;
        for (int b = 0; b < XLEN_BYTES; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reindeer_mm_timer_hub_if.sv
// Wishbone read and write master buses of the timer hub, bundled so the hub
// and the fabric (or a bench) share one definition.
interface reindeer_mm_timer_hub_if #(parameter int ADDR_BITS = 16);
    import reindeer_mm_timer_hub_pkg::*;

    logic                  WB_RD_CYC_O;
    logic                  WB_RD_STB_O;
    logic [ADDR_BITS-1:0]  WB_RD_ADR_O;
    logic [XLEN-1:0]       WB_RD_DAT_I;
    logic                  WB_RD_ACK_I;

    logic                  WB_WR_CYC_O;
    logic                  WB_WR_STB_O;
    logic                  WB_WR_WE_O;
    logic [XLEN_BYTES-1:0] WB_WR_SEL_O;
    logic [ADDR_BITS-1:0]  WB_WR_ADR_O;
    logic [XLEN-1:0]       WB_WR_DAT_O;
    logic                  WB_WR_ACK_I;

    modport master (
        output WB_RD_CYC_O, WB_RD_STB_O, WB_RD_ADR_O,
        input  WB_RD_DAT_I, WB_RD_ACK_I,
        output WB_WR_CYC_O, WB_WR_STB_O, WB_WR_WE_O, WB_WR_SEL_O, WB_WR_ADR_O, WB_WR_DAT_O,
        input  WB_WR_ACK_I
    );

    modport slave (
        input  WB_RD_CYC_O, WB_RD_STB_O, WB_RD_ADR_O,
        output WB_RD_DAT_I, WB_RD_ACK_I,
        input  WB_WR_CYC_O, WB_WR_STB_O, WB_WR_WE_O, WB_WR_SEL_O, WB_WR_ADR_O, WB_WR_DAT_O,
        output WB_WR_ACK_I
    );

endinterface

// File: rtl/reindeer_mtime_prescaler.sv
// Prescale counter and 64-bit mtime register; software writes to either half
// of mtime take priority over the tick increment in the same cycle.
module reindeer_mtime_prescaler
    import reindeer_mm_timer_hub_pkg::*;
#(
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic [PRESCALE_BITS-1:0] prescaler,
    input  logic                     prescaler_wr,
    input  logic                     mtime_lo_wr,
    input  logic                     mtime_hi_wr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [XLEN_BYTES-1:0]    wr_be,
    output logic [63:0]              mtime
);

    logic [PRESCALE_BITS-1:0] count;
    logic                     tick;

    assign tick = (count == prescaler);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (sync_reset || prescaler_wr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime <= '0;
        end else if (sync_reset) begin
            mtime <= '0;
        end else if (mtime_lo_wr) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], wr_data, wr_be);
        end else if (mtime_hi_wr) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], wr_data, wr_be);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/reindeer_mm_timer_hub.sv
// Reindeer timer hub: local mtime/compare registers plus registered Wishbone
// read and write masters that forward every non-local address with a timeout.
module reindeer_mm_timer_hub
    import reindeer_mm_timer_hub_pkg::*;
#(
    parameter int              NUM_CMP       = 4,
    parameter int              ADDR_BITS     = 16,
    parameter int              PRESCALE_BITS = 8,
    parameter int              WB_TIMEOUT    = 255,
    parameter logic [XLEN-1:0] ERR_WORD      = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  data_read_enable,
    input  logic [XLEN_BYTES-1:0] data_write_enable,
    input  logic [ADDR_BITS-1:0]  data_rw_addr,
    input  logic [XLEN-1:0]       data_write_word,
    reindeer_mm_timer_hub_if.master wb,
    output logic                  enable_out,
    output logic [XLEN-1:0]       word_out,
    output logic                  write_busy,
    output logic                  bus_error,
    output logic [NUM_CMP-1:0]    timer_irq,
    output logic                  timer_triggered
);

    localparam logic [ADDR_BITS-1:0] LOCAL_TOP = ADDR_BITS'(local_top(NUM_CMP));
    localparam int                   TMO_BITS  = $clog2(WB_TIMEOUT + 1);
    localparam logic [TMO_BITS-1:0]  TMO_LAST  = TMO_BITS'(WB_TIMEOUT - 1);

    logic [0:0]               rd_state, wr_state;
    logic [TMO_BITS-1:0]      rd_timer, wr_timer;
    logic                     rd_err, wr_err;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic [NUM_CMP-1:0]       irq_en, cmp_hit;
    logic [63:0]              cmp [NUM_CMP];
    logic [63:0]              mtime;
    logic [XLEN-1:0]          local_rdata;
    logic                     is_local, wr_accept, local_wr, ext_wr;

    // Writes are only taken while the write master is idle, local or not.
    assign is_local  = (data_rw_addr <= LOCAL_TOP);
    assign wr_accept = (|data_write_enable) && (wr_state == ST_IDLE) && !sync_reset;
    assign local_wr  = wr_accept && is_local;
    assign ext_wr    = wr_accept && !is_local;

    assign write_busy      = (wr_state == ST_WAIT) || ext_wr;
    assign bus_error       = rd_err || wr_err;
    assign timer_irq       = cmp_hit & irq_en;
    assign timer_triggered = |timer_irq;

    reindeer_mtime_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_presc (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_reset   (sync_reset),
        .prescaler    (prescaler),
        .prescaler_wr (local_wr && data_rw_addr == ADDR_BITS'(REG_PRESCALER)),
        .mtime_lo_wr  (local_wr && data_rw_addr == ADDR_BITS'(REG_MTIME_LO)),
        .mtime_hi_wr  (local_wr && data_rw_addr == ADDR_BITS'(REG_MTIME_HI)),
        .wr_data      (data_write_word),
        .wr_be        (data_write_enable),
        .mtime        (mtime)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            irq_en    <= '0;
        end else if (sync_reset) begin
            prescaler <= '0;
            irq_en    <= '0;
        end else if (local_wr) begin
            if (data_rw_addr == ADDR_BITS'(REG_PRESCALER)) begin
                prescaler <= PRESCALE_BITS'(merge_bytes(XLEN'(prescaler), data_write_word, data_write_enable));
            end
            if (data_rw_addr == ADDR_BITS'(REG_IRQ_EN)) begin
                irq_en <= NUM_CMP'(merge_bytes(XLEN'(irq_en), data_write_word, data_write_enable));
            end
        end
    end

    // Compare registers reset to all-ones so no channel fires before it is set up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CMP; k++) cmp[k] <= '1;
            cmp_hit <= '0;
        end else if (sync_reset) begin
            for (int k = 0; k < NUM_CMP; k++) cmp[k] <= '1;
            cmp_hit <= '0;
        end else begin
            for (int k = 0; k < NUM_CMP; k++) begin
                cmp_hit[k] <= (mtime >= cmp[k]);
                if (local_wr && data_rw_addr == ADDR_BITS'(CMP_BASE + 2 * k)) begin
                    cmp[k][31:0] <= merge_bytes(cmp[k][31:0], data_write_word, data_write_enable);
                end
                if (local_wr && data_rw_addr == ADDR_BITS'(CMP_BASE + 2 * k + 1)) begin
                    cmp[k][63:32] <= merge_bytes(cmp[k][63:32], data_write_word, data_write_enable);
                end
            end
        end
    end

    always_comb begin
        local_rdata = '0;
        if (data_rw_addr == ADDR_BITS'(REG_MTIME_LO))   local_rdata = mtime[31:0];
        if (data_rw_addr == ADDR_BITS'(REG_MTIME_HI))   local_rdata = mtime[63:32];
        if (data_rw_addr == ADDR_BITS'(REG_PRESCALER))  local_rdata[PRESCALE_BITS-1:0] = prescaler;
        if (data_rw_addr == ADDR_BITS'(REG_IRQ_EN))     local_rdata[NUM_CMP-1:0] = irq_en;
        if (data_rw_addr == ADDR_BITS'(REG_IRQ_STATUS)) local_rdata[NUM_CMP-1:0] = cmp_hit;
        for (int k = 0; k < NUM_CMP; k++) begin
            if (data_rw_addr == ADDR_BITS'(CMP_BASE + 2 * k))     local_rdata = cmp[k][31:0];
            if (data_rw_addr == ADDR_BITS'(CMP_BASE + 2 * k + 1)) local_rdata = cmp[k][63:32];
        end
    end

    // Read master; local reads also return through word_out one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state       <= ST_IDLE;
            rd_timer       <= '0;
            rd_err         <= 1'b0;
            enable_out     <= 1'b0;
            word_out       <= '0;
            wb.WB_RD_CYC_O <= 1'b0;
            wb.WB_RD_STB_O <= 1'b0;
            wb.WB_RD_ADR_O <= '0;
        end else if (sync_reset) begin
            rd_state       <= ST_IDLE;
            rd_timer       <= '0;
            rd_err         <= 1'b0;
            enable_out     <= 1'b0;
            word_out       <= '0;
            wb.WB_RD_CYC_O <= 1'b0;
            wb.WB_RD_STB_O <= 1'b0;
            wb.WB_RD_ADR_O <= '0;
        end else begin
            enable_out <= 1'b0;
            rd_err     <= 1'b0;
            if (rd_state == ST_IDLE) begin
                if (data_read_enable && is_local) begin
                    enable_out <= 1'b1;
                    word_out   <= local_rdata;
                end else if (data_read_enable) begin
                    wb.WB_RD_ADR_O <= data_rw_addr;
                    wb.WB_RD_CYC_O <= 1'b1;
                    wb.WB_RD_STB_O <= 1'b1;
                    rd_timer       <= '0;
                    rd_state       <= ST_WAIT;
                end
            end else if (wb.WB_RD_ACK_I || rd_timer == TMO_LAST) begin
                wb.WB_RD_CYC_O <= 1'b0;
                wb.WB_RD_STB_O <= 1'b0;
                enable_out     <= 1'b1;
                word_out       <= wb.WB_RD_ACK_I ? wb.WB_RD_DAT_I : ERR_WORD;
                rd_err         <= !wb.WB_RD_ACK_I;
                rd_state       <= ST_IDLE;
            end else begin
                rd_timer <= rd_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state       <= ST_IDLE;
            wr_timer       <= '0;
            wr_err         <= 1'b0;
            wb.WB_WR_CYC_O <= 1'b0;
            wb.WB_WR_STB_O <= 1'b0;
            wb.WB_WR_WE_O  <= 1'b0;
            wb.WB_WR_SEL_O <= '0;
            wb.WB_WR_ADR_O <= '0;
            wb.WB_WR_DAT_O <= '0;
        end else if (sync_reset) begin
            wr_state       <= ST_IDLE;
            wr_timer       <= '0;
            wr_err         <= 1'b0;
            wb.WB_WR_CYC_O <= 1'b0;
            wb.WB_WR_STB_O <= 1'b0;
            wb.WB_WR_WE_O  <= 1'b0;
            wb.WB_WR_SEL_O <= '0;
            wb.WB_WR_ADR_O <= '0;
            wb.WB_WR_DAT_O <= '0;
        end else begin
            wr_err <= 1'b0;
            if (wr_state == ST_IDLE) begin
                if (ext_wr) begin
                    wb.WB_WR_SEL_O <= data_write_enable;
                    wb.WB_WR_ADR_O <= data_rw_addr;
                    wb.WB_WR_DAT_O <= data_write_word;
                    wb.WB_WR_CYC_O <= 1'b1;
                    wb.WB_WR_STB_O <= 1'b1;
                    wb.WB_WR_WE_O  <= 1'b1;
                    wr_timer       <= '0;
                    wr_state       <= ST_WAIT;
                end
            end else if (wb.WB_WR_ACK_I || wr_timer == TMO_LAST) begin
                wb.WB_WR_CYC_O <= 1'b0;
                wb.WB_WR_STB_O <= 1'b0;
                wb.WB_WR_WE_O  <= 1'b0;
                wr_err         <= !wb.WB_WR_ACK_I;
                wr_state       <= ST_IDLE;
            end else begin
                wr_timer <= wr_timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reindeer_mm_timer_hub.sv
// Directed bench for the Reindeer timer hub with hand-computed expectations.
module tb_reindeer_mm_timer_hub;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_reset;
    logic        data_read_enable;
    logic [3:0]  data_write_enable;
    logic [15:0] data_rw_addr;
    logic [31:0] data_write_word;
    logic        enable_out;
    logic [31:0] word_out;
    logic        write_busy;
    logic        bus_error;
    logic [3:0]  timer_irq;
    logic        timer_triggered;

    int          total = 0;
    int          bad = 0;
    int          stb_cnt;
    logic        got_en;
    logic        err_seen;
    logic [31:0] rd_word;

    reindeer_mm_timer_hub_if #(.ADDR_BITS(16)) wb ();

    reindeer_mm_timer_hub dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sync_reset        (sync_reset),
        .data_read_enable  (data_read_enable),
        .data_write_enable (data_write_enable),
        .data_rw_addr      (data_rw_addr),
        .data_write_word   (data_write_word),
        .wb                (wb),
        .enable_out        (enable_out),
        .word_out          (word_out),
        .write_busy        (write_busy),
        .bus_error         (bus_error),
        .timer_irq         (timer_irq),
        .timer_triggered   (timer_triggered)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
        data_rw_addr      = addr;
        data_write_word   = data;
        data_write_enable = be;
        @(negedge clk);
        data_write_enable = '0;
    endtask

    task automatic checkRead(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        logic        v;
        logic [31:0] w;
        data_rw_addr     = addr;
        data_read_enable = 1'b1;
        @(negedge clk);
        data_read_enable = 1'b0;
        v = enable_out;
        w = word_out;
        checkOutput(tag, {31'd0, v, w}, {31'd0, 1'b1, exp});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n           = 1'b0;
        sync_reset        = 1'b0;
        data_read_enable  = 1'b0;
        data_write_enable = '0;
        data_rw_addr      = '0;
        data_write_word   = '0;
        wb.WB_RD_DAT_I    = '0;
        wb.WB_RD_ACK_I    = 1'b0;
        wb.WB_WR_ACK_I    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_outs", {enable_out, write_busy, bus_error, timer_triggered, timer_irq,
                                   wb.WB_RD_CYC_O, wb.WB_RD_STB_O, wb.WB_WR_CYC_O, wb.WB_WR_STB_O, wb.WB_WR_WE_O}, '0);
        checkOutput("reset_word", word_out, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        checkRead("cmp0_lo_rst", 16'd8, 32'hFFFF_FFFF);
        checkRead("cmp3_hi_rst", 16'd15, 32'hFFFF_FFFF);
        checkRead("presc_rst", 16'd2, 32'h0);
        checkRead("irq_en_rst", 16'd3, 32'h0);

        // prescaler = 3: four cycles per tick
        applyStimulus(16'd2, 32'd3, 4'hF);
        applyStimulus(16'd0, 32'd0, 4'hF);
        repeat (40) @(negedge clk);
        checkRead("mtime_presc3", 16'd0, 32'd10);
        checkRead("presc_rb", 16'd2, 32'd3);

        applyStimulus(16'd10, 32'h1234_5678, 4'b0011);
        checkRead("cmp1_lo_be", 16'd10, 32'hFFFF_5678);
        applyStimulus(16'd6, 32'h55, 4'hF);
        checkRead("rsvd6", 16'd6, 32'h0);

        // compare channel 2 at 20, channel 0 at 0 but masked
        applyStimulus(16'd2, 32'd0, 4'hF);
        applyStimulus(16'd0, 32'd0, 4'hF);
        applyStimulus(16'd12, 32'd20, 4'hF);
        applyStimulus(16'd13, 32'd0, 4'hF);
        applyStimulus(16'd8, 32'd0, 4'hF);
        applyStimulus(16'd9, 32'd0, 4'hF);
        applyStimulus(16'd3, 32'h4, 4'hF);
        repeat (15) @(negedge clk);
        checkOutput("irq_at_mtime20", {timer_triggered, timer_irq}, 5'b0_0000);
        @(negedge clk);
        checkOutput("irq_after_mtime20", {timer_triggered, timer_irq}, 5'b1_0100);
        checkRead("irq_status", 16'd4, 32'h5);

        // 32-bit carry into mtime_hi, then write during tick
        applyStimulus(16'd1, 32'd0, 4'hF);
        applyStimulus(16'd0, 32'hFFFF_FFFF, 4'hF);
        checkRead("wrap_hi0", 16'd1, 32'd0);
        checkRead("wrap_lo", 16'd0, 32'd0);
        checkRead("wrap_hi1", 16'd1, 32'd1);
        applyStimulus(16'd0, 32'h1000, 4'hF);
        checkRead("wr_vs_tick", 16'd0, 32'h1000);

        // external read, ACK on third strobe cycle
        data_rw_addr     = 16'h0100;
        data_read_enable = 1'b1;
        @(negedge clk);
        data_read_enable = 1'b0;
        checkOutput("rd_adr", {wb.WB_RD_CYC_O, wb.WB_RD_ADR_O}, {1'b1, 16'h0100});
        stb_cnt = 0;
        got_en  = 1'b0;
        err_seen = 1'b0;
        rd_word = '0;
        for (int i = 0; i < 20 && !got_en; i++) begin
            if (wb.WB_RD_STB_O) stb_cnt++;
            wb.WB_RD_ACK_I = wb.WB_RD_STB_O && (stb_cnt == 3);
            wb.WB_RD_DAT_I = wb.WB_RD_ACK_I ? 32'h1234_5678 : 32'h0BAD_0BAD;
            @(negedge clk);
            if (enable_out) begin
                got_en   = 1'b1;
                rd_word  = word_out;
                err_seen = bus_error;
            end
        end
        wb.WB_RD_ACK_I = 1'b0;
        checkOutput("ack_valid", got_en, 1);
        checkOutput("ack_stb_cycles", stb_cnt, 3);
        checkOutput("ack_word", rd_word, 32'h1234_5678);
        checkOutput("ack_no_error", err_seen, 0);

        // external read with no ACK: timeout after 255 strobe cycles
        data_rw_addr     = 16'h0200;
        data_read_enable = 1'b1;
        @(negedge clk);
        data_read_enable = 1'b0;
        stb_cnt = 0;
        got_en  = 1'b0;
        for (int i = 0; i < 300 && !got_en; i++) begin
            if (wb.WB_RD_STB_O) stb_cnt++;
            if (i == 10) begin
                data_rw_addr     = 16'h0002;
                data_read_enable = 1'b1;
            end else begin
                data_read_enable = 1'b0;
            end
            @(negedge clk);
            if (enable_out) begin
                got_en   = 1'b1;
                rd_word  = word_out;
                err_seen = bus_error;
            end
        end
        data_read_enable = 1'b0;
        checkOutput("tmo_valid", got_en, 1);
        checkOutput("tmo_stb_cycles", stb_cnt, 255);
        checkOutput("tmo_word", rd_word, 32'hDEAD_BEEF);
        checkOutput("tmo_bus_error", err_seen, 1);
        checkOutput("tmo_stb_low", wb.WB_RD_STB_O, 0);
        @(negedge clk);
        checkOutput("bus_error_pulse", bus_error, 0);

        // external write, ACK on second strobe, second request while busy
        data_rw_addr      = 16'h0300;
        data_write_word   = 32'hCAFE_F00D;
        data_write_enable = 4'b0011;
        #1;
        checkOutput("busy_req", write_busy, 1);
        @(negedge clk);
        checkOutput("wr_bus", {wb.WB_WR_CYC_O, wb.WB_WR_STB_O, wb.WB_WR_WE_O, wb.WB_WR_SEL_O,
                               wb.WB_WR_ADR_O, wb.WB_WR_DAT_O}, {3'b111, 4'b0011, 16'h0300, 32'hCAFE_F00D});
        stb_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (wb.WB_WR_STB_O) stb_cnt++;
            wb.WB_WR_ACK_I = wb.WB_WR_STB_O && (stb_cnt == 2);
            if (i == 0) begin
                data_rw_addr      = 16'h0304;
                data_write_word   = 32'h1111_1111;
                data_write_enable = 4'hF;
            end else begin
                data_write_enable = '0;
            end
            if (i == 1) checkOutput("busy_ack_cycle", write_busy, 1);
            if (i == 2) checkOutput("busy_after_ack", write_busy, 0);
            @(negedge clk);
        end
        wb.WB_WR_ACK_I = 1'b0;
        checkOutput("wr_stb_cycles", stb_cnt, 2);

        // both masters active, then asynchronous reset mid-wait
        data_rw_addr      = 16'h0400;
        data_write_word   = 32'h1;
        data_write_enable = 4'hF;
        data_read_enable  = 1'b1;
        @(negedge clk);
        data_write_enable = '0;
        data_read_enable  = 1'b0;
        checkOutput("both_fsm_active", {wb.WB_RD_STB_O, wb.WB_WR_STB_O, timer_irq}, {2'b11, 4'b0100});
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_outs", {enable_out, write_busy, bus_error, timer_triggered, timer_irq,
                                       wb.WB_RD_CYC_O, wb.WB_RD_STB_O, wb.WB_WR_CYC_O, wb.WB_WR_STB_O, wb.WB_WR_WE_O}, '0);
        checkOutput("async_rst_word", word_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkRead("cmp2_lo_after_rst", 16'd12, 32'hFFFF_FFFF);

        // synchronous clear
        applyStimulus(16'd3, 32'hF, 4'hF);
        checkRead("irq_en_set", 16'd3, 32'hF);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        checkRead("irq_en_sync_clr", 16'd3, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reindeer_mm_timer_hub.md
Name: reindeer_mm_timer_hub

Overview:
Parametrised next-generation memory-mapped register block for the Reindeer core. It provides one 64-bit mtime counter with a programmable prescaler and NUM_CMP independent 64-bit compare channels, each with its own interrupt enable. Registered Wishbone read and write masters forward all non-local addresses to the external bus, with a handshake hold and a timeout. It sits between the core's data load/store port and the peripheral Wishbone fabric.

Parameters:
NUM_CMP, 4, number of compare channels (1..8)
ADDR_BITS, 16, word-address width of data_rw_addr and the WB address buses
PRESCALE_BITS, 8, width of the prescaler register and counter
WB_TIMEOUT, 255, cycles of STB without ACK before a bus error (at least 1)
ERR_WORD, 32'hDEAD_BEEF, word_out value returned on a read timeout

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous clear, same effect as reset
data_read_enable  in  1  read request pulse
data_write_enable  in  XLEN_BYTES  byte write enables; nonzero means write
data_rw_addr  in  ADDR_BITS  word address
data_write_word  in  XLEN  write data
WB_RD_CYC_O / WB_RD_STB_O  out  1  read cycle / strobe, registered
WB_RD_ADR_O  out  ADDR_BITS  read address, registered
WB_RD_DAT_I  in  XLEN  read data
WB_RD_ACK_I  in  1  read acknowledge
WB_WR_CYC_O / WB_WR_STB_O / WB_WR_WE_O  out  1  write cycle / strobe / enable, registered
WB_WR_SEL_O  out  XLEN_BYTES  byte selects
WB_WR_ADR_O  out  ADDR_BITS  write address
WB_WR_DAT_O  out  XLEN  write data
WB_WR_ACK_I  in  1  write acknowledge
enable_out  out  1  read-data-valid pulse
word_out  out  XLEN  read data, registered
write_busy  out  1  external write pending; core must stall further writes
bus_error  out  1  one-cycle pulse on any WB timeout
timer_irq  out  NUM_CMP  per-channel interrupt
timer_triggered  out  1  OR of timer_irq

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low. Reset and sync_reset put every output at 0, mtime at 0, prescaler at 0, irq_en at 0, every cmp at all-ones, and both FSMs in IDLE. Any pending WB cycle is dropped without an ack.
- Local map (word addresses): 0 mtime_lo; 1 mtime_hi; 2 prescaler; 3 irq_en[NUM_CMP-1:0]; 4 irq_status (read-only raw compare bits); 5..7 reserved (read 0, writes ignored); 8+2k cmp_lo[k]; 9+2k cmp_hi[k].
- LOCAL_TOP = 7+2*NUM_CMP. An address <= LOCAL_TOP is local; anything above is external.
- Local writes honour byte enables.
- Prescaler tick: the prescale counter counts 0..prescaler. A tick is issued when counter == prescaler, and the counter then returns to 0. prescaler = 0 gives a tick every cycle. A prescaler write also clears the counter.
- mtime increments by 1 on each tick; 64-bit wrap from all-ones to 0.
- A software write to mtime_lo or mtime_hi in the same cycle as a tick: the written word takes the written value, the other half keeps its value, and no increment is applied that cycle.
- Compare: cmp_hit[k] is registered (mtime >= cmp[k], unsigned 64-bit), so it lags mtime by 1 cycle. timer_irq[k] = cmp_hit[k] & irq_en[k].
- Local read: enable_out = 1 exactly 1 cycle after data_read_enable, with word_out registered in the same cycle.
- Read FSM, IDLE to WAIT: an external read latches the address and asserts CYC/STB the next cycle.
- Read FSM, WAIT: STB is held until WB_RD_ACK_I. The cycle after the ACK, enable_out = 1, word_out = WB_RD_DAT_I as captured, and the FSM returns to IDLE.
- Read timeout: after WB_TIMEOUT cycles without an ACK, STB drops, enable_out = 1, word_out = ERR_WORD, bus_error = 1, and the FSM returns to IDLE.
- data_read_enable during WAIT is dropped.
- Write FSM, IDLE to WAIT: an external write registers SEL/ADR/DAT and asserts CYC/STB/WE the next cycle. write_busy = 1 from the request cycle (combinational on the request) until the ACK cycle inclusive.
- Write FSM, WAIT: STB is held until WB_WR_ACK_I, then the FSM returns to IDLE.
- Write timeout: same rule as reads; bus_error pulses and the write is lost.
- A write request while write_busy is dropped.
- Read and write FSMs are independent and may both be active in the same cycle.
- A write request with data_write_enable == 0 is not a write.

Decomposition:
- Shared package / common.vh: local register offsets, CMP_BASE = 8, a LOCAL_TOP(n) macro, and FSM state encodings IDLE/WAIT.
- One natural sub-module: reindeer_mtime_prescaler, which holds the prescale counter, the mtime register, and the write-versus-tick priority logic.

Test Plan:
- Write prescaler = 3, run 40 cycles -> mtime = 10 (+/-1 for the phase); tick seen every 4th cycle.
- Write cmp_lo[2] = 20, cmp_hi[2] = 0, irq_en = 4'b0100 -> timer_irq = 4'b0100 and timer_triggered = 1 on the cycle after mtime reaches 20; channels 0, 1 and 3 stay 0.
- Write mtime_lo = 32'hFFFF_FFFF, mtime_hi = 0, with prescaler = 0 -> next cycle mtime_hi = 1, mtime_lo = 0. Also write mtime_lo during a tick -> the written value is kept with no increment.
- External read at addr 0x100, slave ACKs after 3 cycles with 32'h1234_5678 -> STB high for 3 cycles; enable_out pulses 1 cycle after ACK with word_out = 32'h1234_5678.
- External read with no ACK and WB_TIMEOUT = 255 -> STB drops after 255 cycles; enable_out = 1, word_out = 32'hDEAD_BEEF, bus_error pulse.
- External write with SEL = 4'b0011, slave ACKs after 2 cycles, and a second write issued while busy -> only one WB write occurs; write_busy = 1 until the ACK. Assert reset_n low mid-WAIT -> all outputs go to 0 asynchronously.
